serial_subtractor: RTL

//  Multi-cycle, parametrised N-bit subtracter: computes {borrowOut, diff} = a - b - borrowIn
//  one DIGIT_W-bit digit per clock, LSB digit first, with the borrow chained between cycles.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/digit_subtract.sv | 17 +
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtracter.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that indexes 0..digits-1, never narrower than one bit.
  function automatic int cnt_width(input int digits);
    return (digits <= 1) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/digit_subtract.sv
// One DIGIT_W-bit subtract stage with borrow: {bo, d} = x - y - bi.
module digit_subtract #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] x_i,
  input  logic [DIGIT_W-1:0] y_i,
  input  logic               bi_i,
  output logic [DIGIT_W-1:0] d_o,
  output logic               bo_o
);

  // The extra top bit of the difference is the outgoing borrow.
  always_comb begin
    {bo_o, d_o} = {1'b0, x_i} - {1'b0, y_i} - {{DIGIT_W{1'b0}}, bi_i};
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtracter {borrowOut, diff} = a - b - borrowIn, LSB digit first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W  = cnt_width(DIGITS);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  generate
    if (WIDTH < 2 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >=2 and a multiple of DIGIT_W");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bo_q, bo_d;

  logic [DIGIT_W-1:0] dig_d;
  logic               dig_bo;
  logic [WIDTH-1:0]   res_shift;
  logic               accept;

  digit_subtract #(.DIGIT_W(DIGIT_W)) u_digit (
    .x_i  (a_q[DIGIT_W-1:0]),
    .y_i  (b_q[DIGIT_W-1:0]),
    .bi_i (borrow_q),
    .d_o  (dig_d),
    .bo_o (dig_bo)
  );

  // New digits enter at the top so the LSB digit ends up at bit 0 after DIGITS shifts.
  assign res_shift = (res_q >> DIGIT_W) | (WIDTH'(dig_d) << (WIDTH - DIGIT_W));
  assign accept    = start && (state_q != RUN);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bo_d     = bo_q;

    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        a_d      = a_q >> DIGIT_W;
        b_d      = b_q >> DIGIT_W;
        res_d    = res_shift;
        borrow_d = dig_bo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIGIT) begin
          state_d = DONE;
          diff_d  = res_shift;
          bo_d    = dig_bo;
        end
      end
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d      = a;
      b_d      = b;
      borrow_d = borrowIn;
      cnt_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bo_q     <= bo_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign diff      = diff_q;
  assign borrowOut = bo_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out during RUN, so keep them for the overflow rule.
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (state_q == RUN && cnt_q == LAST_DIGIT) begin
        ovf_q <= (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
      end
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
